// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module : seq_alu
// Registered ALU with valid/ready handshakes on both sides and a
// multi-cycle shift-add multiply; one operation in flight at a time.
// Rev    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataX,
    input  logic [WIDTH-1:0] dataY,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_sll  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_slt  = 4'd8;
    localparam logic [3:0] c_op_sltu = 4'd9;
    localparam logic [3:0] c_op_mul  = 4'd10;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mul  = 1'b1;

    // Counter needs SHW+1 bits to hold the initial value WIDTH.
    localparam logic [SHW:0] c_cnt_init = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] c_cnt_one  = (SHW+1)'(1);

    logic [0:0]       r_state;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_negative;
    logic             r_carry;
    logic             r_overflow;
    logic             r_out_valid;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_in_ready;

    assign w_in_ready = (r_state == c_st_idle) && (!r_out_valid || out_ready);
    assign w_shamt    = dataY[SHW-1:0];
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_sum  = {1'b0, dataX} + {1'b0, dataY};
        w_diff = {1'b0, dataX} - {1'b0, dataY};
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (control)
            c_op_add: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (dataX[WIDTH-1] == dataY[WIDTH-1]) && (w_sum[WIDTH-1] != dataX[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (dataX[WIDTH-1] != dataY[WIDTH-1]) && (w_diff[WIDTH-1] != dataX[WIDTH-1]);
            end
            c_op_and:  w_res = dataX & dataY;
            c_op_or:   w_res = dataX | dataY;
            c_op_xor:  w_res = dataX ^ dataY;
            c_op_sll:  w_res = dataX << w_shamt;
            c_op_srl:  w_res = dataX >> w_shamt;
            c_op_sra:  w_res = $signed(dataX) >>> w_shamt;
            c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(dataX) < $signed(dataY))};
            c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (dataX < dataY)};
            default:   w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_negative  <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // A new result registered below overrides this clear.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (in_valid && w_in_ready) begin
                        if (control == c_op_mul) begin
                            r_mcand  <= dataX;
                            r_mplier <= dataY;
                            r_acc    <= '0;
                            r_cnt    <= c_cnt_init;
                            r_state  <= c_st_mul;
                        end else begin
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_negative  <= w_res[WIDTH-1];
                            r_carry     <= w_c;
                            r_overflow  <= w_v;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                c_st_mul: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_negative  <= w_acc_next[WIDTH-1];
                        r_carry     <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign busy      = (r_state == c_st_mul);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_alu
// Directed self-checking bench for seq_alu (WIDTH = 32).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] dataX = '0;
    logic [WIDTH-1:0] dataY = '0;
    logic [3:0]       control = 4'd0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataX     (dataX),
        .dataY     (dataY),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        control  = op;
        dataX    = x;
        dataY    = y;
    endtask

    // Flags are compared as {zero, negative, carry, overflow}.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input logic [3:0] exp_flg);
        drive(op, x, y);
        chk({tag, "_inrdy"}, in_ready, 1);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flags"}, {zero, negative, carry, overflow}, exp_flg);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_res, input bit hold);
        int  n;
        bit  busy_ok;
        drive(4'd10, x, y);
        step();
        if (hold) drive(4'd0, 32'd5, 32'd6);
        else      in_valid = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 64) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 32);
        chk({tag, "_busy_inrdy"}, busy_ok, 1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_flags"}, {zero, negative, carry, overflow}, 4'b0000);
    endtask

    initial begin
        // Reset with random inputs toggling.
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            control   = 4'($urandom_range(0, 15));
            dataX     = $urandom;
            dataY     = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("rst_valid", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_flags", {zero, negative, carry, overflow}, 4'b1000);
        chk("rst_inrdy", in_ready, 1);
        chk("rst_busy", busy, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        step();
        chk("idle_valid", out_valid, 0);

        // Back-to-back single-cycle ops with out_ready held high.
        single("add_carry", 4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1010);
        single("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0101);
        single("sub_borrow",4'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0110);
        single("sub_ovf",   4'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0001);
        single("sra",       4'd7, 32'h8000_0000, 32'h21,        32'hC000_0000, 4'b0100);
        single("srl",       4'd6, 32'h8000_0000, 32'h21,        32'h4000_0000, 4'b0000);
        single("sll",       4'd5, 32'h1,         32'h3F,        32'h8000_0000, 4'b0100);
        single("slt",       4'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000);
        single("sltu",      4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1000);
        single("and",       4'd2, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 4'b0000);
        single("or",        4'd3, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000);
        single("xor",       4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 4'b0100);
        in_valid = 1'b0;
        step();
        chk("drain1", out_valid, 0);

        // Multiply with a held ADD that must wait until the multiply finishes.
        run_mul("mul1", 32'h0001_2345, 32'h0000_1000, 32'h1234_5000, 1'b1);
        step();
        chk("held_add_res", result, 32'd11);
        chk("held_add_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        run_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);
        step();
        chk("drain2", out_valid, 0);

        // Back-pressure: result holds, input blocked, then transfer+accept on one edge.
        out_ready = 1'b0;
        drive(4'd0, 32'd1, 32'd2);
        step();
        drive(4'd1, 32'd10, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_res", result, 32'd3);
            chk("bp_valid", out_valid, 1);
            chk("bp_inrdy", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_inrdy", in_ready, 1);
        step();
        chk("bp_next_res", result, 32'd6);
        chk("bp_next_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        chk("drain3", out_valid, 0);

        // Reset during a multiply aborts it.
        drive(4'd10, 32'd7, 32'd9);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("abort_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_res", result, 0);
        chk("abort_inrdy", in_ready, 1);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_result", out_valid, 0);
        end
        single("undef13", 4'd13, 32'h55, 32'hAA, 32'h0, 4'b1000);
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the combinational datapath ALU. It adds shifts, signed/unsigned compares and a multi-cycle shift-add multiply, plus a full flag set. Operands enter and results leave through valid/ready handshakes, so the block can sit between the register-read stage and the writeback stage with back-pressure from either side. One operation is in flight at a time.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, derived, `$clog2(WIDTH)`: shift-amount width. Not overridable.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand/op presented.
- `in_ready` out 1: block can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `dataX` in WIDTH: operand X.
- `dataY` in WIDTH: operand Y; the low SHW bits are the shift amount for shifts.
- `control` in 4: opcode. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL. Values 11–15 are undefined ops.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer accepts; transfer occurs when `out_valid && out_ready` at a rising edge.
- `result` out WIDTH: registered result.
- `zero` out 1: `result == 0`.
- `negative` out 1: `result[WIDTH-1]`.
- `carry` out 1:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: borrow, i.e. `dataX < dataY` unsigned.
  - All other ops: 0.
- `overflow` out 1:
  - ADD/SUB: signed overflow.
  - All other ops: 0.
- `busy` out 1: high while in MUL state.

## Operation
- **States:** IDLE, MUL.
- **Input ready:** `in_ready = (state == IDLE) && (!out_valid || out_ready)`. The output register is never overwritten before it is consumed.
- **IDLE, accept of op ≠ MUL:** compute the result combinationally and register result and flags. `out_valid` is set. State stays IDLE.
- **Arithmetic and logic ops:**
  - ADD/SUB are computed at WIDTH+1 bits for carry/borrow.
  - AND/OR/XOR are bitwise.
- **Shifts:**
  - SLL/SRL shift logically.
  - SRA sign-fills.
  - Shift amount is `dataY[SHW-1:0]`; upper bits are ignored.
- **Compares:** SLT/SLTU return 1 or 0, zero-extended to WIDTH.
- **Undefined ops (11–15):** accepted like any single-cycle op; result 0, `zero` 1, other flags 0.
- **IDLE, accept of MUL:**
  - Latch multiplicand = dataX and multiplier = dataY; clear accumulator; load iteration counter = WIDTH.
  - Go to MUL; `busy` is 1.
- **MUL, each cycle:**
  - If multiplier[0], add multiplicand to accumulator, modulo 2^WIDTH.
  - Shift multiplicand left by 1 and multiplier right by 1; decrement counter.
  - When the counter reaches 0 after the update, register the accumulator as result, set `out_valid`, and return to IDLE.
  - Result is the low WIDTH bits of the product. `zero`/`negative` are per the result; `carry`/`overflow` are 0.
- **Output handshake:**
  - `out_valid` clears on an output transfer unless a new result is registered on the same edge.
  - result and flags hold stable while `out_valid && !out_ready`.
- **Back-to-back operation:** with `out_ready` held at 1, single-cycle ops accept one op per cycle. Output transfer and new input accept on the same edge are allowed.
- **Input while busy:** `in_valid` during MUL is ignored (`in_ready` = 0). The input must be held by the producer.

## Timing
- **Reset values:** while `reset_n` = 0, asynchronously:
  - state IDLE, counter 0, `out_valid` 0, result 0, `zero` 1.
  - `negative`, `carry`, `overflow`, `busy` 0.
  - `in_ready` 1.
- **Reset mid-MUL:** aborts the multiply; no result is emitted; reset values apply.
- **Single-cycle latency:** accept at edge N → `out_valid` = 1 after edge N (observable in cycle N+1).
- **MUL latency:**
  - Accept at edge N → `busy` = 1 from N through N+WIDTH-1.
  - `out_valid` = 1 after edge N+WIDTH, with `busy` 0 at the same time.
  - `in_ready` is 0 during those WIDTH cycles.
- **Stall:** if `out_valid` = 1 and `out_ready` = 0, then `in_ready` = 0. Nothing changes until `out_ready` rises.
- **Combinational path:** `in_ready` is combinational only on `out_ready`, `out_valid` and state. No input-to-output combinational path otherwise.

## Test plan
- **Reset:** hold `reset_n` = 0, drive random inputs → `out_valid` 0, result 0, `zero` 1, `in_ready` 1. Release → first accept works.
- **Add/sub flags (WIDTH=32, `out_ready` = 1):**
  - ADD 0xFFFFFFFF + 1 → result 0, `zero` 1, `carry` 1, `overflow` 0, latency 1.
  - ADD 0x7FFFFFFF + 1 → 0x80000000, `overflow` 1, `negative` 1.
  - SUB 3 − 5 → 0xFFFFFFFE, `carry` 1.
- **Shifts and compares:**
  - SRA 0x80000000 by `dataY` = 0x21 (shamt 1) → 0xC0000000.
  - SRL same → 0x40000000.
  - SLT −1 vs 1 → 1; SLTU same → 0.
- **Multiply:**
  - MUL 0x12345 × 0x1000 → 0x12345000, `out_valid` exactly 32 cycles after accept edge, `busy` 1 for 32 cycles, `in_ready` 0 throughout.
  - MUL 0xFFFFFFFF × 0xFFFFFFFF → 1.
- **Back-pressure:** issue ADD 1+2 with `out_ready` 0 for 5 cycles → result 3 held stable, `in_ready` 0. Then raise `out_ready` with the next op valid → transfer and accept on the same edge, next result 1 cycle later.
- **Abort and undefined op:** assert `reset_n` = 0 at MUL cycle 10 → no result, state IDLE. After release, op 13 → result 0, `zero` 1, latency 1.
